uart_cal_ctrl: RTL and testbench

- Command sequencer for the UART calculator.
- Consumes bytes from the UART receiver, parses the ASCII expression `<hexA><op><hexB>=`, computes a 16-bit result, then drives the UART transmitter byte-by-byte with the 4-digit hex result followed by CR LF.
- Sits between the rx block and tx block. It is the only master of the tx byte interface.

---
 rtl/uart_cal_pkg.sv | 31 +++
 rtl/uart_cal_hexconv.sv | 27 ++
 rtl/uart_cal_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_uart_cal_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cal_pkg.sv
// Shared types and ASCII constants for the UART calculator command sequencer.
package uart_cal_pkg;

  localparam int OPW = 16;

  typedef enum logic [2:0] {
    GET_A,
    GET_B,
    CALC,
    TX_CHAR,
    TX_WAIT
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD,
    OP_SUB,
    OP_MUL,
    OP_AND
  } op_e;

  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_STAR  = 8'h2A;
  localparam logic [7:0] CH_AMP   = 8'h26;
  localparam logic [7:0] CH_EQ    = 8'h3D;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_QM    = 8'h3F;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;

endpackage

// File: rtl/uart_cal_hexconv.sv
// Combinational hex converter: ASCII -> {valid, nibble} and nibble -> uppercase ASCII.
module uart_cal_hexconv (
  input  logic [7:0] asc_i,
  output logic       asc_valid_o,
  output logic [3:0] asc_nib_o,
  input  logic [3:0] nib_i,
  output logic [7:0] nib_asc_o
);

  always_comb begin
    asc_valid_o = 1'b0;
    asc_nib_o   = '0;
    if (asc_i >= 8'h30 && asc_i <= 8'h39) begin
      asc_valid_o = 1'b1;
      asc_nib_o   = asc_i[3:0];
    end else if ((asc_i >= 8'h41 && asc_i <= 8'h46) ||
                 (asc_i >= 8'h61 && asc_i <= 8'h66)) begin
      asc_valid_o = 1'b1;
      asc_nib_o   = asc_i[3:0] + 4'd9;
    end
  end

  always_comb begin
    nib_asc_o = (nib_i < 4'd10) ? {4'h3, nib_i} : 8'h37 + {4'h0, nib_i};
  end

endmodule

// File: rtl/uart_cal_ctrl.sv
// UART calculator sequencer: parses "<hexA><op><hexB>=", computes a 16-bit
// result and streams it to the transmitter as 4 hex digits plus CR [LF].
module uart_cal_ctrl
  import uart_cal_pkg::*;
#(
  parameter int MAX_DIGITS = 4,
  parameter bit LF_EN      = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic       busy,
  output logic       err
);

  localparam int CW = $clog2(MAX_DIGITS + 1);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [OPW-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_start_q, tx_start_d, busy_q, busy_d, err_q, err_d;
  logic             is_err_q, is_err_d, guard_q, guard_d, rx_valid_q;

  logic             strobe, dec_valid, is_op, perr;
  logic [3:0]       dec_nib, enc_nib;
  logic [7:0]       enc_asc, cur_byte;
  logic [2:0]       seq_len;
  op_e              op_dec;
  logic [7:0]       dec_asc_unused;
  logic             enc_valid_unused;
  logic [3:0]       enc_nib_unused;

  uart_cal_hexconv u_dec (
    .asc_i       (rx_data),
    .asc_valid_o (dec_valid),
    .asc_nib_o   (dec_nib),
    .nib_i       ('0),
    .nib_asc_o   (dec_asc_unused)
  );

  uart_cal_hexconv u_enc (
    .asc_i       ('0),
    .asc_valid_o (enc_valid_unused),
    .asc_nib_o   (enc_nib_unused),
    .nib_i       (enc_nib),
    .nib_asc_o   (enc_asc)
  );

  assign strobe = rx_valid & ~rx_valid_q;

  // Outgoing byte is derived from the latched result and sequence index.
  always_comb begin
    enc_nib = res_q[3:0];
    case (idx_q)
      3'd0:    enc_nib = res_q[15:12];
      3'd1:    enc_nib = res_q[11:8];
      3'd2:    enc_nib = res_q[7:4];
      default: enc_nib = res_q[3:0];
    endcase
    if (is_err_q) begin
      cur_byte = (idx_q == 3'd0) ? CH_QM : (idx_q == 3'd1) ? CH_CR : CH_LF;
      seq_len  = LF_EN ? 3'd3 : 3'd2;
    end else begin
      cur_byte = (idx_q < 3'd4) ? enc_asc : (idx_q == 3'd4) ? CH_CR : CH_LF;
      seq_len  = LF_EN ? 3'd6 : 3'd5;
    end
  end

  always_comb begin
    is_op  = 1'b1;
    op_dec = OP_ADD;
    case (rx_data)
      CH_PLUS:  op_dec = OP_ADD;
      CH_MINUS: op_dec = OP_SUB;
      CH_STAR:  op_dec = OP_MUL;
      CH_AMP:   op_dec = OP_AND;
      default:  is_op  = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    busy_d     = busy_q;
    err_d      = 1'b0;
    is_err_d   = is_err_q;
    guard_d    = guard_q;
    perr       = 1'b0;

    case (state_q)
      GET_A, GET_B: begin
        if (strobe) begin
          if (dec_valid) begin
            if (cnt_q == CW'(MAX_DIGITS)) begin
              perr = 1'b1;
            end else begin
              if (state_q == GET_A) a_d = {a_q[OPW-5:0], dec_nib};
              else                  b_d = {b_q[OPW-5:0], dec_nib};
              cnt_d = cnt_q + CW'(1);
            end
          end else if (rx_data == CH_SP) begin
            state_d = state_q;
          end else if (is_op && state_q == GET_A && cnt_q != '0) begin
            op_d    = op_dec;
            cnt_d   = '0;
            state_d = GET_B;
          end else if (rx_data == CH_EQ && state_q == GET_B && cnt_q != '0) begin
            busy_d  = 1'b1;
            state_d = CALC;
          end else begin
            perr = 1'b1;
          end
        end
        if (perr) begin
          err_d    = 1'b1;
          busy_d   = 1'b1;
          is_err_d = 1'b1;
          idx_d    = '0;
          state_d  = TX_CHAR;
        end
      end
      CALC: begin
        case (op_q)
          OP_ADD:  res_d = a_q + b_q;
          OP_SUB:  res_d = a_q - b_q;
          OP_MUL:  res_d = a_q * b_q;
          default: res_d = a_q & b_q;
        endcase
        is_err_d = 1'b0;
        idx_d    = '0;
        state_d  = TX_CHAR;
      end
      TX_CHAR: begin
        if (!tx_busy) begin
          tx_data_d  = cur_byte;
          tx_start_d = 1'b1;
          guard_d    = 1'b1;
          state_d    = TX_WAIT;
        end
      end
      TX_WAIT: begin
        // tx_busy only rises the cycle after tx_start, so skip one cycle first.
        if (guard_q) begin
          guard_d = 1'b0;
        end else if (!tx_busy) begin
          if (idx_q == seq_len - 3'd1) begin
            a_d     = '0;
            b_d     = '0;
            cnt_d   = '0;
            busy_d  = 1'b0;
            state_d = GET_A;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = TX_CHAR;
          end
        end
      end
      default: state_d = GET_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= GET_A;
      op_q       <= OP_ADD;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      is_err_q   <= 1'b0;
      guard_q    <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_q      <= res_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      is_err_q   <= is_err_d;
      guard_q    <= guard_d;
      rx_valid_q <= rx_valid;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule

// File: tb/tb_uart_cal_ctrl.sv
// Self-checking bench for uart_cal_ctrl against a string-level expression model.
module tb_uart_cal_ctrl;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy = 1'b0;
  logic       busy;
  logic       err;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] cap[$];
  int err_cycles = 0;
  int start_viol = 0;
  int busy_len = 4;
  int busy_cnt = 0;
  int since_start = 100;
  logic pending = 1'b0;

  always #10 clk = ~clk;

  uart_cal_ctrl #(.MAX_DIGITS(4), .LF_EN(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .busy     (busy),
    .err      (err)
  );

  // Transmitter model: busy rises after a start and stays high busy_len cycles.
  always @(negedge clk) begin
    err_cycles  <= err_cycles + (err ? 1 : 0);
    since_start <= tx_start ? 0 : since_start + 1;
    if (tx_start) begin
      if (tx_busy || pending || since_start < 1) start_viol <= start_viol + 1;
      cap.push_back(tx_data);
      pending <= 1'b1;
    end else if (pending) begin
      pending  <= 1'b0;
      busy_cnt <= busy_len;
      tx_busy  <= 1'b1;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) tx_busy <= 1'b0;
    end
  end

  function automatic int hexval(input byte c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    return -1;
  endfunction

  // Reference: evaluates the command text; stops at '=' or the first bad character.
  function automatic void model(input string s, output bq_t exp, output int n_send,
                                output int n_err);
    int st = 0;
    int cnt = 0;
    int op = 0;
    int nib;
    int unsigned a = 0, b = 0, r = 0;
    byte c;
    bit bad;
    string hexs = "0123456789ABCDEF";
    exp = {};
    n_send = s.len();
    n_err = 0;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      nib = hexval(c);
      bad = 1'b0;
      if (c == " ") continue;
      if (nib >= 0) begin
        if (cnt == 4) bad = 1'b1;
        else begin
          if (st == 0) a = (a * 16 + nib) % 65536;
          else         b = (b * 16 + nib) % 65536;
          cnt++;
        end
      end else if (c == "+" || c == "-" || c == "*" || c == "&") begin
        if (st == 0 && cnt > 0) begin
          op = (c == "+") ? 0 : (c == "-") ? 1 : (c == "*") ? 2 : 3;
          st = 1;
          cnt = 0;
        end else bad = 1'b1;
      end else if (c == "=" && st == 1 && cnt > 0) begin
        case (op)
          0: r = (a + b) % 65536;
          1: r = (a + 65536 - b) % 65536;
          2: r = (a * b) % 65536;
          default: r = a & b;
        endcase
        exp.push_back(hexs[(r >> 12) & 15]);
        exp.push_back(hexs[(r >> 8) & 15]);
        exp.push_back(hexs[(r >> 4) & 15]);
        exp.push_back(hexs[r & 15]);
        exp.push_back(8'h0D);
        exp.push_back(8'h0A);
        n_send = i + 1;
        return;
      end else bad = 1'b1;
      if (bad) begin
        exp.push_back(8'h3F);
        exp.push_back(8'h0D);
        exp.push_back(8'h0A);
        n_err = 1;
        n_send = i + 1;
        return;
      end
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    repeat (hold) @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic run_cmd(input string name, input string s, input int hold, input int gap,
                         input int blen);
    bq_t exp;
    int n_send, n_err, base, e0, v0, to, limit, got;
    model(s, exp, n_send, n_err);
    busy_len = blen;
    base = cap.size();
    e0 = err_cycles;
    v0 = start_viol;
    for (int i = 0; i < n_send; i++) send_byte(s[i], hold, gap);
    limit = exp.size() * (blen + 10) + 500;
    to = 0;
    while (!((cap.size() - base) >= exp.size() && busy === 1'b0 && tx_busy === 1'b0)
           && to < limit) begin
      @(negedge clk);
      to++;
    end
    repeat (3) @(negedge clk);
    got = cap.size() - base;
    vectors++;
    if (to >= limit) begin
      miscompares++;
      $display("FAIL %s timeout: busy=%0b bytes=%0d required idle with %0d bytes", name, busy,
               got, exp.size());
    end
    vectors++;
    if (got !== exp.size()) begin
      miscompares++;
      $display("FAIL %s byte_count: got %0d required %0d", name, got, exp.size());
    end
    for (int i = 0; i < exp.size() && i < got; i++) begin
      vectors++;
      if (cap[base+i] !== exp[i]) begin
        miscompares++;
        $display("FAIL %s byte[%0d]: got 0x%02h required 0x%02h", name, i, cap[base+i],
                 exp[i]);
      end
    end
    vectors++;
    if ((err_cycles - e0) !== n_err) begin
      miscompares++;
      $display("FAIL %s err_cycles: got %0d required %0d", name, err_cycles - e0, n_err);
    end
    vectors++;
    if ((start_viol - v0) !== 0) begin
      miscompares++;
      $display("FAIL %s tx_start_spacing: got %0d violations required 0", name,
               start_viol - v0);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    vectors++;
    if ({tx_data, tx_start, busy, err} !== 11'h000) begin
      miscompares++;
      $display("FAIL %s: tx_data=0x%02h tx_start=%0b busy=%0b err=%0b required all 0", name,
               tx_data, tx_start, busy, err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    vectors++;
    if (tx_start !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_tx_start: got %0b required 0", tx_start);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_arith();
    run_cmd("add", "1A+5=", 2, 2, 6);
    run_cmd("wrap", "FFFF+2=", 3, 1, 5);
    run_cmd("borrow", "3-5=", 1, 1, 3);
    run_cmd("mul_low", "100*100=", 2, 2, 4);
  endtask

  task automatic test_errors();
    run_cmd("too_many_digits", "12345", 2, 1, 4);
    run_cmd("after_error", "2&3=", 2, 1, 4);
    run_cmd("op_first", "+3=", 2, 1, 4);
    run_cmd("eq_in_a", "7=", 2, 1, 4);
    run_cmd("spaces_lower", "a + b =", 2, 1, 4);
    run_cmd("bad_char", "12G", 1, 1, 2);
  endtask

  task automatic test_long_hold();
    run_cmd("long_hold", "1A+5=", 450, 5, 4000);
  endtask

  task automatic test_reset_mid();
    int base, to;
    busy_len = 40;
    base = cap.size();
    for (int i = 0; i < 6; i++) begin
      string s = "12+34=";
      send_byte(s[i], 2, 1);
    end
    to = 0;
    while ((cap.size() - base) < 2 && to < 1000) begin
      @(negedge clk);
      to++;
    end
    vectors++;
    if (to >= 1000) begin
      miscompares++;
      $display("FAIL reset_mid_reach_byte2: got %0d bytes required 2", cap.size() - base);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("reset_mid_outputs");
    repeat (200) @(negedge clk);
    vectors++;
    if ((cap.size() - base) !== 2) begin
      miscompares++;
      $display("FAIL reset_mid_no_more_tx: got %0d bytes required 2", cap.size() - base);
    end
    run_cmd("after_reset", "1+1=", 2, 1, 5);
  endtask

  task automatic test_random();
    string ops = "+-*&";
    for (int n = 0; n < 12; n++) begin
      string s = "";
      int nd;
      byte ch;
      for (int opnd = 0; opnd < 2; opnd++) begin
        nd = ($urandom_range(0, 7) == 0) ? 5 : int'($urandom_range(1, 4));
        for (int d = 0; d < nd; d++) begin
          int v = int'($urandom_range(0, 15));
          if (v < 10) ch = byte'(48 + v);
          else ch = byte'(($urandom_range(0, 1) ? 65 : 97) + v - 10);
          s = $sformatf("%s%c", s, ch);
          if ($urandom_range(0, 9) == 0) s = {s, " "};
        end
        if (opnd == 0) s = $sformatf("%s%c", s, ops[$urandom_range(0, 3)]);
      end
      s = {s, "="};
      if ($urandom_range(0, 5) == 0) s = {"x", s};
      run_cmd($sformatf("random%0d", n), s, int'($urandom_range(1, 4)),
              int'($urandom_range(1, 3)), int'($urandom_range(1, 10)));
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_errors();
    test_random();
    test_reset_mid();
    test_long_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
